// File: rtl/uart_ctl_pkg.sv
// Shared constants for the UART controller: register map, CSR bit positions
// and FSM state encodings.
package uart_ctl_pkg;

  localparam logic [1:0] A_RCSR = 2'd0;
  localparam logic [1:0] A_RBUF = 2'd1;
  localparam logic [1:0] A_XCSR = 2'd2;
  localparam logic [1:0] A_XBUF = 2'd3;

  localparam int B_DONE  = 7;
  localparam int B_READY = 7;
  localparam int B_IE    = 6;
  localparam int B_OR    = 14;
  localparam int B_ERR   = 15;

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL, T_DRAIN} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} rx_state_t;

endpackage

// File: rtl/uart_baudgen.sv
// Serial clock generator: rxclk at 16x baud from a clk divider, txclk at 1x
// baud derived from rising edges of rxclk.
module uart_baudgen #(
  parameter int RX_HALF = 163
) (
  input  logic clk,
  input  logic reset,
  output logic txclk,
  output logic rxclk
);

  localparam int DW = (RX_HALF > 1) ? $clog2(RX_HALF) : 1;

  logic [DW-1:0] div;
  logic [2:0]    rise_cnt;

  // rise_cnt advances on each 0->1 transition of rxclk; txclk flips every 8th
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      rxclk    <= 1'b0;
      rise_cnt <= '0;
      txclk    <= 1'b0;
    end else if (div == DW'(RX_HALF - 1)) begin
      div   <= '0;
      rxclk <= ~rxclk;
      if (!rxclk) begin
        rise_cnt <= rise_cnt + 3'd1;
        if (rise_cnt == 3'd7) txclk <= ~txclk;
      end
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/uart_ctl.sv
// Register front-end for a UART: CSR/buffer registers plus the load/unload
// handshakes. Define UART_CTL_INT_EN to enable the IE bits and interrupts.
module uart_ctl
  import uart_ctl_pkg::*;
#(
  parameter int RX_HALF = 163
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        rx_int,
  output logic        tx_int,
  output logic        txclk,
  output logic        rxclk,
  output logic        ld_tx_req,
  input  logic        ld_tx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  input  logic        tx_empty,
  output logic        uld_rx_req,
  input  logic        uld_rx_ack,
  input  logic [7:0]  rx_data,
  output logic        rx_enable,
  input  logic        rx_empty
);

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [3:0] sync1, sync2;
  logic       ld_ack_s, uld_ack_s, tx_empty_s, rx_empty_s;
  logic       tx_ready, capture, rd_rbuf, wr_xbuf;
  logic [7:0] rbuf;
  logic       done, ovr, rie, tie;
  logic       unused;

  assign unused = ^{data_in[15:8], data_in[6:0]};

  uart_baudgen #(.RX_HALF(RX_HALF)) u_baudgen (
    .clk   (clk),
    .reset (reset),
    .txclk (txclk),
    .rxclk (rxclk)
  );

  // Bit order {rx_empty, tx_empty, uld_rx_ack, ld_tx_ack}; empties reset high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b1100;
      sync2 <= 4'b1100;
    end else begin
      sync1 <= {rx_empty, tx_empty, uld_rx_ack, ld_tx_ack};
      sync2 <= sync1;
    end
  end
  assign {rx_empty_s, tx_empty_s, uld_ack_s, ld_ack_s} = sync2;

  assign rd_rbuf = sel && !wr && (addr == A_RBUF);
  assign wr_xbuf = sel && wr && (addr == A_XBUF);

  // TX FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= T_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (wr_xbuf)     tx_next = T_REQ;
      T_REQ:   if (ld_ack_s)    tx_next = T_REL;
      T_REL:   if (!ld_ack_s)   tx_next = T_DRAIN;
      T_DRAIN: if (tx_empty_s)  tx_next = T_IDLE;
      default:                  tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    ld_tx_req = (tx_state == T_REQ);
    tx_ready  = (tx_state == T_IDLE);
  end

  // RX FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_empty_s) rx_next = R_REQ;
      R_REQ:   if (uld_ack_s)   rx_next = R_REL;
      R_REL:   if (!uld_ack_s)  rx_next = R_IDLE;
      default:                  rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    uld_rx_req = (rx_state == R_REQ);
    capture    = (rx_state == R_REL) && !uld_ack_s;
  end

  // A read racing a capture consumes the old character, so no overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data   <= '0;
      rbuf      <= '0;
      done      <= 1'b0;
      ovr       <= 1'b0;
      tx_enable <= 1'b0;
      rx_enable <= 1'b0;
    end else begin
      tx_enable <= 1'b1;
      rx_enable <= 1'b1;
      if (tx_ready && wr_xbuf) tx_data <= data_in[7:0];
      if (capture) begin
        rbuf <= rx_data;
        done <= 1'b1;
        ovr  <= done && !rd_rbuf;
      end else if (rd_rbuf) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
    end
  end

`ifdef UART_CTL_INT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rie    <= 1'b0;
      tie    <= 1'b0;
      rx_int <= 1'b0;
      tx_int <= 1'b0;
    end else begin
      if (sel && wr && addr == A_RCSR) rie <= data_in[B_IE];
      if (sel && wr && addr == A_XCSR) tie <= data_in[B_IE];
      rx_int <= done && rie;
      tx_int <= tx_ready && tie;
    end
  end
`else
  assign rie    = 1'b0;
  assign tie    = 1'b0;
  assign rx_int = 1'b0;
  assign tx_int = 1'b0;
`endif

  // XBUF is write-only and reads back as zero
  always_comb begin
    data_out = '0;
    if (sel && !wr) begin
      case (addr)
        A_RCSR: begin
          data_out[B_DONE] = done;
          data_out[B_IE]   = rie;
        end
        A_RBUF: begin
          data_out[7:0]   = rbuf;
          data_out[B_OR]  = ovr;
          data_out[B_ERR] = ovr;
        end
        A_XCSR: begin
          data_out[B_READY] = tx_ready;
          data_out[B_IE]    = tie;
        end
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctl.sv
// Scoreboard bench for uart_ctl: register reads push expected data, a monitor
// compares on every read strobe. Handshake peers are modelled inline.
module tb_uart_ctl;
  import uart_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel, wr;
  logic [1:0]  addr;
  logic [15:0] data_in, data_out;
  logic        rx_int, tx_int, txclk, rxclk;
  logic        ld_tx_req, ld_tx_ack, tx_enable, tx_empty;
  logic [7:0]  tx_data, rx_data;
  logic        uld_rx_req, uld_rx_ack, rx_enable, rx_empty;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  string       nm_q[$];

  uart_ctl #(.RX_HALF(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rx_int(rx_int), .tx_int(tx_int),
    .txclk(txclk), .rxclk(rxclk), .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_empty(tx_empty),
    .uld_rx_req(uld_rx_req), .uld_rx_ack(uld_rx_ack), .rx_data(rx_data),
    .rx_enable(rx_enable), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  // Monitor: every read strobe is checked against the oldest expectation
  always @(negedge clk) begin
    if (sel && !wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read actual=%h required=<none>", data_out);
      end else begin
        logic [15:0] e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL %s actual=%h required=%h", n, data_out, e);
        end
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return ld_tx_req;
      1:       return uld_rx_req;
      2:       return rxclk;
      default: return txclk;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int w, input logic v, input string nm);
    int n = 0;
    while (sig(w) !== v && n < 100) begin
      step();
      n++;
    end
    chk(nm, {15'b0, sig(w)}, {15'b0, v});
  endtask

  // Rising-edge to rising-edge period in clk cycles; -1 on timeout
  task automatic period(input int w, output int p);
    int n = 0;
    p = -1;
    while (sig(w) !== 1'b0 && n < 400) begin step(); n++; end
    while (sig(w) !== 1'b1 && n < 400) begin step(); n++; end
    p = 0;
    while (sig(w) !== 1'b0 && n < 400) begin step(); n++; p++; end
    while (sig(w) !== 1'b1 && n < 400) begin step(); n++; p++; end
    if (n >= 400) p = -1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; data_in = d;
    step();
    sel = 1'b0; wr = 1'b0; data_in = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    sel = 1'b1; wr = 1'b0; addr = a;
    step();
    sel = 1'b0;
  endtask

  // UART side of one receive; with race set, RBUF is read in the capture cycle
  task automatic recv(input logic [7:0] d, input bit race, input logic [15:0] race_exp);
    rx_data  = d;
    rx_empty = 1'b0;
    wait_for(1, 1'b1, "rx_req_up");
    uld_rx_ack = 1'b1;
    rx_empty   = 1'b1;
    wait_for(1, 1'b0, "rx_req_down");
    uld_rx_ack = 1'b0;
    if (race) begin
      step(2);
      rd_reg(A_RBUF, race_exp, "rbuf_race_old");
      step(4);
    end else begin
      step(6);
    end
  endtask

  initial begin
    int p;
    reset = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    ld_tx_ack = 1'b0; tx_empty = 1'b1; uld_rx_ack = 1'b0; rx_empty = 1'b1;
    rx_data = '0;
    step(3);
    chk("rst_ld_tx_req", {15'b0, ld_tx_req}, 16'h0);
    chk("rst_uld_rx_req", {15'b0, uld_rx_req}, 16'h0);
    chk("rst_clks", {14'b0, txclk, rxclk}, 16'h0);
    chk("rst_enables", {14'b0, tx_enable, rx_enable}, 16'h0);
    chk("rst_data_out_idle", data_out, 16'h0);
    chk("rst_ints", {14'b0, tx_int, rx_int}, 16'h0);
    reset = 1'b0;
    step();
    chk("enables_after_rst", {14'b0, tx_enable, rx_enable}, 16'h3);
    rd_reg(A_RCSR, 16'h0000, "rcsr_rst");
    rd_reg(A_RBUF, 16'h0000, "rbuf_rst");
    rd_reg(A_XCSR, 16'h0080, "xcsr_rst");

    period(2, p);
    chk("rxclk_period", 16'(p), 16'd4);
    period(3, p);
    chk("txclk_period", 16'(p), 16'd64);

    // Transmit one character; a second XBUF write while busy is dropped
    wr_reg(A_XBUF, 16'h0041);
    rd_reg(A_XCSR, 16'h0000, "xcsr_busy");
    wr_reg(A_XBUF, 16'h0099);
    wait_for(0, 1'b1, "tx_req_up");
    chk("tx_data", {8'b0, tx_data}, 16'h0041);
    ld_tx_ack = 1'b1;
    tx_empty  = 1'b0;
    wait_for(0, 1'b0, "tx_req_down");
    ld_tx_ack = 1'b0;
    step(8);
    rd_reg(A_XCSR, 16'h0000, "xcsr_drain");
    tx_empty = 1'b1;
    step(4);
    rd_reg(A_XCSR, 16'h0080, "xcsr_ready");
    chk("tx_data_kept", {8'b0, tx_data}, 16'h0041);
    step(6);
    chk("tx_no_second_req", {15'b0, ld_tx_req}, 16'h0);

    // Single receive
    recv(8'h5A, 1'b0, 16'h0);
    rd_reg(A_RCSR, 16'h0080, "rcsr_done");
    rd_reg(A_RBUF, 16'h005A, "rbuf_5a");
    rd_reg(A_RCSR, 16'h0000, "rcsr_cleared");

    // Overrun: two characters without an intervening read
    recv(8'h11, 1'b0, 16'h0);
    recv(8'h22, 1'b0, 16'h0);
    rd_reg(A_RBUF, 16'hC022, "rbuf_overrun");
    rd_reg(A_RCSR, 16'h0000, "rcsr_after_or");
    rd_reg(A_RBUF, 16'h0022, "rbuf_or_cleared");

    // Read coinciding with capture: capture wins, no overrun
    recv(8'h44, 1'b0, 16'h0);
    recv(8'h55, 1'b1, 16'h0044);
    rd_reg(A_RCSR, 16'h0080, "rcsr_race_done");
    rd_reg(A_RBUF, 16'h0055, "rbuf_race_new");

    // Reset in the middle of a transmit handshake
    wr_reg(A_XBUF, 16'h0077);
    wait_for(0, 1'b1, "tx_req_before_rst");
    reset = 1'b1;
    #1;
    chk("rst_mid_req", {15'b0, ld_tx_req}, 16'h0);
    step(2);
    reset = 1'b0;
    step(2);
    rd_reg(A_XCSR, 16'h0080, "xcsr_after_rst");
    rd_reg(A_RCSR, 16'h0000, "rcsr_after_rst");
    chk("tx_data_after_rst", {8'b0, tx_data}, 16'h0);

`ifdef UART_CTL_INT_EN
    wr_reg(A_RCSR, 16'h00FF);
    rd_reg(A_RCSR, 16'h0040, "rcsr_ie_only");
    recv(8'h33, 1'b0, 16'h0);
    chk("rx_int_set", {15'b0, rx_int}, 16'h1);
    rd_reg(A_RCSR, 16'h00C0, "rcsr_done_ie");
    rd_reg(A_RBUF, 16'h0033, "rbuf_33");
    step(2);
    chk("rx_int_clr", {15'b0, rx_int}, 16'h0);
    chk("tx_int_off", {15'b0, tx_int}, 16'h0);
    wr_reg(A_XCSR, 16'h0040);
    step(2);
    chk("tx_int_set", {15'b0, tx_int}, 16'h1);
    rd_reg(A_XCSR, 16'h00C0, "xcsr_ready_ie");
`else
    wr_reg(A_RCSR, 16'h00FF);
    rd_reg(A_RCSR, 16'h0000, "rcsr_no_ie");
    recv(8'h33, 1'b0, 16'h0);
    chk("rx_int_tied", {15'b0, rx_int}, 16'h0);
    rd_reg(A_RCSR, 16'h0080, "rcsr_done_no_ie");
    wr_reg(A_XCSR, 16'h0040);
    step(2);
    rd_reg(A_XCSR, 16'h0080, "xcsr_no_ie");
    chk("tx_int_tied", {15'b0, tx_int}, 16'h0);
`endif

    step(4);
    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_ctl.md
UART_CTL -- requirements
Module: uart_ctl

Interface
REQ-001 Parameter RX_HALF, default 163: clk cycles per half-period of rxclk (16x baud; 50 MHz -> ~9600 baud).
REQ-002 clk  in  1  system clock; all logic is on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 sel  in  1  register access strobe, valid for one clk.
REQ-005 wr  in  1  write qualifier; when low, a selected access is a read.
REQ-006 addr  in  2  register select: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF.
REQ-007 data_in  in  16  write data.
REQ-008 data_out  out  16  combinational read data for addr; 0 when sel is low.
REQ-009 rx_int, tx_int  out  1  interrupt requests.
REQ-010 txclk, rxclk  out  1  generated serial clocks: rxclk at 16x baud, txclk at 1x baud.
REQ-011 ld_tx_req  out  1; ld_tx_ack  in  1; tx_data  out  8; tx_enable  out  1; tx_empty  in  1: transmit handshake to the UART.
REQ-012 uld_rx_req  out  1; uld_rx_ack  in  1; rx_data  in  8; rx_enable  out  1; rx_empty  in  1: receive handshake to the UART.

Function
REQ-013 rxclk toggles every RX_HALF clk cycles; txclk toggles on every 8th rising edge of rxclk (period = 16 rxclk periods).
REQ-014 ld_tx_ack, uld_rx_ack, tx_empty and rx_empty pass through 2-flop synchronizers (reset values 0, 0, 1, 1); the FSMs use only the synchronized copies.
REQ-015 TX FSM states: T_IDLE, T_REQ, T_REL, T_DRAIN.
REQ-016 T_IDLE: on a write to XBUF, latch data_in[7:0] into tx_data and go to T_REQ; writes to XBUF outside T_IDLE are ignored.
REQ-017 T_REQ: ld_tx_req=1 until synced ack=1, then T_REL.
REQ-018 T_REL: ld_tx_req=0 until synced ack=0, then T_DRAIN.
REQ-019 T_DRAIN: wait for synced tx_empty=1, then T_IDLE.
REQ-020 XCSR bit7 READY = (state==T_IDLE).
REQ-021 RX FSM states: R_IDLE, R_REQ, R_REL.
REQ-022 R_IDLE: when synced rx_empty=0, go to R_REQ.
REQ-023 R_REQ: uld_rx_req=1 until synced ack=1, then R_REL.
REQ-024 R_REL: uld_rx_req=0 until synced ack=0; in that cycle capture rx_data into RBUF[7:0], set DONE and go to R_IDLE.
REQ-025 RCSR bit7 DONE: set on capture, cleared by a read of RBUF.
REQ-026 RBUF bit14 OR is set on capture while DONE=1; bit15 ERR=OR; a read of RBUF clears OR.
REQ-027 Simultaneous RBUF read and capture: capture wins (DONE=1, OR=0, new data).
REQ-028 Unused register bits read 0; writes to RCSR/XCSR affect only bit6.
REQ-029 tx_enable and rx_enable are registered 1 after reset release.

Reset
REQ-030 Reset values: all FSMs idle, ld_tx_req=0, uld_rx_req=0, tx_data=0, RBUF=0, DONE=0, OR=0, IE bits=0, txclk=rxclk=0, dividers=0, tx_enable=rx_enable=0, rx_int=tx_int=0.
REQ-031 Reset asserted mid-handshake returns the block to idle immediately; no partial character is reported.

Configuration
REQ-032 Macro UART_CTL_INT_EN defined: RCSR/XCSR bit6 are read/write IE bits; rx_int = DONE & RCSR.IE; tx_int = READY & XCSR.IE (both registered).
REQ-033 UART_CTL_INT_EN undefined: bit6 reads 0 and ignores writes; rx_int and tx_int are tied to 0.

Structure
REQ-034 Package uart_ctl_pkg holds the register offsets, CSR bit positions and TX/RX state encodings.
REQ-035 Clock generation is sub-module uart_baudgen (params RX_HALF; out txclk, rxclk).

Verification
REQ-036 RX_HALF=2: after reset, rxclk period = 4 clk and txclk period = 64 clk.
REQ-037 Write XBUF=0x41 -> READY=0, then one req/ack cycle, tx_data=0x41, READY=1 after tx_empty returns 1; a second XBUF write while busy is ignored.
REQ-038 UART model drops rx_empty with rx_data=0x5A -> req/ack completes, RBUF reads 0x005A, DONE=1; a subsequent RCSR read returns 0x0000 (IE=0).
REQ-039 Two chars 0x11, 0x22 without an intervening RBUF read -> RBUF=0xC022; reading it clears DONE and OR.
REQ-040 UART_CTL_INT_EN: write RCSR=0x0040, receive 0x33 -> rx_int=1; read RBUF -> rx_int=0; XCSR=0x0040 while idle -> tx_int=1.
REQ-041 Reset asserted in T_REQ -> ld_tx_req=0 at once; READY=1 after release.
